uart_buffered: RTL and testbench

UART_BUFFERED -- requirements
Module: uart_buffered

---
 rtl/uart_buffered.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_uart_buffered.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_buffered.sv
// ---------------------------------------------------------------------------
// uart_buffered
//   Full-duplex UART: a transmitter with a busy handshake and a receiver
//   feeding a show-ahead RX FIFO. Transmitter and receiver share only
//   the clock and the reset.
//
//   Frame: start (0), DATA_BITS data bits LSB first, optional parity bit,
//   STOP_BITS stop bits (1). Every line bit lasts DIV = CLOCK_FREQ/BAUD_RATE
//   clock cycles.
//
// Ports
//   clock       sole clock, rising edge
//   reset       synchronous, active-high reset
//   tx_data     word to transmit, latched when tx_send is accepted
//   tx_send     transmit request, accepted only while tx_busy = 0
//   tx_busy     transmitter occupied with a frame
//   tx          serial output, idle high
//   rx          serial input, asynchronous to clock
//   rx_data     head-of-FIFO data (0 when the FIFO is empty)
//   rx_perr     head entry parity error
//   rx_ferr     head entry framing error
//   rx_valid    FIFO not empty
//   rx_ready    consumer pops the head entry (ignored while empty)
//   rx_level    FIFO occupancy, 0..FIFO_DEPTH
//   rx_overrun  one-cycle pulse when a received frame is dropped (FIFO full)
// ---------------------------------------------------------------------------
module uart_buffered #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [DATA_BITS-1:0]            tx_data,
  input  logic                            tx_send,
  output logic                            tx_busy,
  output logic                            tx,
  input  logic                            rx,
  output logic [DATA_BITS-1:0]            rx_data,
  output logic                            rx_perr,
  output logic                            rx_ferr,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_level,
  output logic                            rx_overrun
);

  localparam int DIV  = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF = ((DIV / 2) > 0) ? (DIV / 2) : 1;
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW   = $clog2(DATA_BITS);
  localparam int LW   = $clog2(FIFO_DEPTH + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int EW   = DATA_BITS + 2;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_WAIT   = 3'd5   // receiver only: line stuck low after a framing error
  } state_t;

  // Parity bit that makes the ones-count over data+parity odd (mode 1) or even.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    logic p;
    if (PARITY == 1) begin
      p = ~(^d);
    end else begin
      p = ^d;
    end
    return p;
  endfunction

  // =========================================================================
  // Transmitter
  // =========================================================================
  state_t               tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic                 tx_stop_q, tx_stop_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_bit_end_s;

  assign tx_bit_end_s = (tx_cnt_q == CNT_LAST);

  // TX next-state: the line value for the next bit is registered together
  // with the state change, so tx switches on the same edge as the FSM.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_stop_d  = tx_stop_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    case (tx_state_q)
      S_IDLE: begin
        if (tx_send) begin
          tx_state_d = S_START;
          tx_cnt_d   = '0;
          tx_shift_d = tx_data;
          tx_par_d   = parity_bit(tx_data);
          tx_d       = 1'b0;
          tx_busy_d  = 1'b1;
        end else begin
          tx_d      = 1'b1;
          tx_busy_d = 1'b0;
        end
      end
      S_START: begin
        if (tx_bit_end_s) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (tx_bit_end_s) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BIT_LAST) begin
            if (PARITY != 0) begin
              tx_state_d = S_PARITY;
              tx_d       = tx_par_q;
            end else begin
              tx_state_d = S_STOP;
              tx_stop_d  = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            tx_bit_d   = tx_bit_q + BW'(1);
            tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (tx_bit_end_s) begin
          tx_state_d = S_STOP;
          tx_cnt_d   = '0;
          tx_stop_d  = 1'b0;
          tx_d       = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (tx_bit_end_s) begin
          tx_cnt_d = '0;
          if (tx_stop_q == STOP_LAST) begin
            // Last stop-bit cycle: busy drops next cycle, which is the one
            // cycle where a back-to-back tx_send gets accepted.
            tx_state_d = S_IDLE;
            tx_busy_d  = 1'b0;
            tx_d       = 1'b1;
          end else begin
            tx_stop_d = 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: begin
        tx_state_d = S_IDLE;
        tx_cnt_d   = '0;
        tx_busy_d  = 1'b0;
        tx_d       = 1'b1;
      end
    endcase
  end

  // TX state register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_stop_q  <= tx_stop_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = tx_busy_q;

  // =========================================================================
  // Receiver
  // =========================================================================
  logic                 rx_meta_q, rx_sync_q;
  state_t               rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_bit_end_s;
  logic                 push_s;
  logic [EW-1:0]        push_entry_s;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign rx_bit_end_s = (rx_cnt_q == CNT_LAST);

  // RX next-state: half-bit start confirmation, then one sample per bit
  // period at bit centre; the push strobe fires at the first stop sample.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_perr_d    = rx_perr_q;
    push_s       = 1'b0;
    push_entry_s = '0;
    case (rx_state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
        end else begin
          rx_cnt_d = '0;
        end
      end
      S_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            rx_state_d = S_IDLE;   // glitch, not a start bit
          end else begin
            rx_state_d = S_DATA;
            rx_bit_d   = '0;
            rx_perr_d  = 1'b0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (rx_bit_end_s) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == BIT_LAST) begin
            if (PARITY != 0) begin
              rx_state_d = S_PARITY;
            end else begin
              rx_state_d = S_STOP;
            end
          end else begin
            rx_bit_d = rx_bit_q + BW'(1);
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (rx_bit_end_s) begin
          rx_cnt_d   = '0;
          rx_perr_d  = (rx_sync_q != parity_bit(rx_shift_q));
          rx_state_d = S_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (rx_bit_end_s) begin
          rx_cnt_d     = '0;
          push_s       = 1'b1;
          push_entry_s = {rx_shift_q, rx_perr_q, ~rx_sync_q};
          if (rx_sync_q) begin
            rx_state_d = S_IDLE;
          end else begin
            rx_state_d = S_WAIT;   // don't mistake a held-low line for a start
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (rx_sync_q) begin
          rx_state_d = S_IDLE;
        end else begin
          rx_state_d = S_WAIT;
        end
      end
      default: begin
        rx_state_d = S_IDLE;
        rx_cnt_d   = '0;
      end
    endcase
  end

  // RX state register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

  // =========================================================================
  // RX FIFO (show-ahead)
  // =========================================================================
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overrun_q, overrun_d;
  logic          pop_s, full_s, wr_en_s;
  logic [EW-1:0] head_s;

  // FIFO control: a push while full is only taken when a pop frees the slot
  // in the same cycle; otherwise the frame is dropped and flagged.
  always_comb begin
    pop_s     = (level_q != '0) && rx_ready;
    full_s    = (level_q == LVL_FULL);
    wr_en_s   = push_s && (!full_s || pop_s);
    overrun_d = push_s && full_s && !pop_s;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO pointer/level/overrun registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
    end
  end

  // FIFO storage; contents need no reset because outputs are masked when empty.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= push_entry_s;
    end
  end

  assign head_s     = mem_q[rd_ptr_q];
  assign rx_valid   = (level_q != '0);
  assign rx_data    = rx_valid ? head_s[EW-1:2] : '0;
  assign rx_perr    = rx_valid ? head_s[1] : 1'b0;
  assign rx_ferr    = rx_valid ? head_s[0] : 1'b0;
  assign rx_level   = level_q;
  assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_buffered.sv
// ---------------------------------------------------------------------------
// tb_uart_buffered
//   Directed bench for uart_buffered. Two instances with a short bit period
//   (DIV = 16): dut_a without parity, dut_b with even parity. Each receiver
//   either listens to its own transmitter (loopback) or to a bench-driven
//   line. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_uart_buffered;

  localparam int CLK_HZ = 160_000;
  localparam int BAUD   = 10_000;
  localparam int DIV    = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [7:0] tx_data;
  logic       tx_send_a, tx_send_b;
  logic       rx_ready_a, rx_ready_b;
  logic       line, lb_a, lb_b, sel;

  logic       tx_a, tx_busy_a, rx_a, rx_perr_a, rx_ferr_a, rx_valid_a, rx_overrun_a;
  logic [7:0] rx_data_a;
  logic [2:0] rx_level_a;
  logic       tx_b, tx_busy_b, rx_b, rx_perr_b, rx_ferr_b, rx_valid_b, rx_overrun_b;
  logic [7:0] rx_data_b;
  logic [2:0] rx_level_b;
  logic       cur_busy, cur_tx;

  assign rx_a     = lb_a ? tx_a : line;
  assign rx_b     = lb_b ? tx_b : line;
  assign cur_busy = sel ? tx_busy_b : tx_busy_a;
  assign cur_tx   = sel ? tx_b : tx_a;

  uart_buffered #(
    .CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_a (
    .clock(clock), .reset(reset), .tx_data(tx_data), .tx_send(tx_send_a),
    .tx_busy(tx_busy_a), .tx(tx_a), .rx(rx_a), .rx_data(rx_data_a),
    .rx_perr(rx_perr_a), .rx_ferr(rx_ferr_a), .rx_valid(rx_valid_a),
    .rx_ready(rx_ready_a), .rx_level(rx_level_a), .rx_overrun(rx_overrun_a)
  );

  uart_buffered #(
    .CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_b (
    .clock(clock), .reset(reset), .tx_data(tx_data), .tx_send(tx_send_b),
    .tx_busy(tx_busy_b), .tx(tx_b), .rx(rx_b), .rx_data(rx_data_b),
    .rx_perr(rx_perr_b), .rx_ferr(rx_ferr_b), .rx_valid(rx_valid_b),
    .rx_ready(rx_ready_b), .rx_level(rx_level_b), .rx_overrun(rx_overrun_b)
  );

  int checks = 0;
  int errors = 0;
  int ovr_a  = 0;

  // Count overrun pulses of dut_a, sampled away from the active edge.
  always @(negedge clock) begin
    if (rx_overrun_a === 1'b1) ovr_a++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Send one word on dut_a (s=0) or dut_b (s=1). Counts busy cycles, returns
  // the line in the first busy cycle and at busy-cycle index samp_at, and
  // re-requests a different word at busy-cycle index poke_at.
  task automatic send(input logic s, input logic [7:0] d, input int poke_at,
                      input int samp_at, output int nbusy,
                      output logic first_tx, output logic samp_tx);
    sel = s;
    @(negedge clock);
    tx_data = d;
    if (s) tx_send_b = 1'b1; else tx_send_a = 1'b1;
    @(negedge clock);
    tx_send_a = 1'b0;
    tx_send_b = 1'b0;
    first_tx  = cur_tx;
    samp_tx   = 1'b1;
    nbusy     = 0;
    while (cur_busy === 1'b1 && nbusy < 1000) begin
      if (nbusy == samp_at) samp_tx = cur_tx;
      if (nbusy == poke_at) begin
        tx_data = ~d;
        if (s) tx_send_b = 1'b1; else tx_send_a = 1'b1;
      end else begin
        tx_send_a = 1'b0;
        tx_send_b = 1'b0;
      end
      nbusy++;
      @(negedge clock);
    end
  endtask

  // Bit-bang one 8-bit frame on the bench line.
  task automatic drive_frame(input logic [7:0] d, input logic with_par,
                             input logic par, input logic stop);
    line = 1'b0;
    repeat (DIV) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      line = d[i];
      repeat (DIV) @(negedge clock);
    end
    if (with_par) begin
      line = par;
      repeat (DIV) @(negedge clock);
    end
    line = stop;
    repeat (DIV) @(negedge clock);
  endtask

  task automatic wait_valid(input logic s, input int maxc);
    int n;
    n = 0;
    while (((s ? rx_valid_b : rx_valid_a) !== 1'b1) && n < maxc) begin
      n++;
      @(negedge clock);
    end
  endtask

  task automatic pop(input logic s);
    if (s) rx_ready_b = 1'b1; else rx_ready_a = 1'b1;
    @(negedge clock);
    rx_ready_a = 1'b0;
    rx_ready_b = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int   n, ovr0;
    logic f, s;
    reset = 1'b1; tx_data = 8'h00; tx_send_a = 1'b0; tx_send_b = 1'b0;
    rx_ready_a = 1'b0; rx_ready_b = 1'b0; line = 1'b1;
    lb_a = 1'b1; lb_b = 1'b1; sel = 1'b0;
    repeat (3) @(negedge clock);

    // Reset state
    check("rst_tx",      32'(tx_a),         32'd1);
    check("rst_busy",    32'(tx_busy_a),    32'd0);
    check("rst_level",   32'(rx_level_a),   32'd0);
    check("rst_valid",   32'(rx_valid_a),   32'd0);
    check("rst_data",    32'(rx_data_a),    32'd0);
    check("rst_perr",    32'(rx_perr_a),    32'd0);
    check("rst_ferr",    32'(rx_ferr_a),    32'd0);
    check("rst_overrun", 32'(rx_overrun_a), 32'd0);
    check("rst_tx_b",    32'(tx_b),         32'd1);
    check("rst_level_b", 32'(rx_level_b),   32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Loopback 0x55, stray tx_send mid-frame must be ignored
    send(1'b0, 8'h55, 50, 24, n, f, s);
    check("lb_busy_len", 32'(n), 32'd160);
    check("lb_start",    32'(f), 32'd0);
    check("lb_bit0",     32'(s), 32'd1);
    wait_valid(1'b0, 64);
    check("lb_valid", 32'(rx_valid_a), 32'd1);
    check("lb_level", 32'(rx_level_a), 32'd1);
    check("lb_data",  32'(rx_data_a),  32'h55);
    check("lb_perr",  32'(rx_perr_a),  32'd0);
    check("lb_ferr",  32'(rx_ferr_a),  32'd0);
    pop(1'b0);
    check("lb_pop_valid", 32'(rx_valid_a), 32'd0);
    rx_ready_a = 1'b1;
    repeat (3) @(negedge clock);
    rx_ready_a = 1'b0;
    check("empty_pop_level", 32'(rx_level_a), 32'd0);
    check("empty_pop_valid", 32'(rx_valid_a), 32'd0);

    // Back-to-back 0x01..0x05 with no pops: fifth frame overruns
    ovr0 = ovr_a;
    for (int i = 1; i <= 5; i++) begin
      tx_data   = 8'(i);
      tx_send_a = 1'b1;
      @(negedge clock);
      check("b2b_accept", 32'(tx_busy_a), 32'd1);
      if (i == 5) tx_send_a = 1'b0;
      n = 1;
      @(negedge clock);
      while (tx_busy_a === 1'b1 && n < 1000) begin
        n++;
        @(negedge clock);
      end
      check("b2b_len", 32'(n), 32'd160);
    end
    tx_send_a = 1'b0;
    repeat (4) @(negedge clock);
    check("fifo_level_full", 32'(rx_level_a), 32'd4);
    check("fifo_overrun_cnt", 32'(ovr_a - ovr0), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check("fifo_pop_valid", 32'(rx_valid_a), 32'd1);
      check("fifo_pop_data",  32'(rx_data_a),  32'(i));
      pop(1'b0);
    end
    check("fifo_drained_valid", 32'(rx_valid_a), 32'd0);
    check("fifo_drained_level", 32'(rx_level_a), 32'd0);

    // Framing error, line held low, then recovery
    lb_a = 1'b0;
    line = 1'b1;
    repeat (4) @(negedge clock);
    drive_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (5 * DIV) @(negedge clock);
    check("ferr_level", 32'(rx_level_a), 32'd1);
    check("ferr_data",  32'(rx_data_a),  32'h3C);
    check("ferr_flag",  32'(rx_ferr_a),  32'd1);
    check("ferr_perr",  32'(rx_perr_a),  32'd0);
    pop(1'b0);
    line = 1'b1;
    repeat (2 * DIV) @(negedge clock);
    check("ferr_no_extra", 32'(rx_level_a), 32'd0);
    drive_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clock);
    check("recov_level", 32'(rx_level_a), 32'd1);
    check("recov_data",  32'(rx_data_a),  32'h3C);
    check("recov_ferr",  32'(rx_ferr_a),  32'd0);
    pop(1'b0);

    // Short low glitch is rejected
    line = 1'b0;
    repeat (4) @(negedge clock);
    line = 1'b1;
    repeat (3 * DIV) @(negedge clock);
    check("glitch_level", 32'(rx_level_a), 32'd0);
    check("glitch_valid", 32'(rx_valid_a), 32'd0);
    lb_a = 1'b1;

    // Even parity: 0xA7 has five ones, so the line parity bit is 1
    send(1'b1, 8'hA7, -1, 152, n, f, s);
    check("par_busy_len", 32'(n), 32'd176);
    check("par_line_bit", 32'(s), 32'd1);
    wait_valid(1'b1, 64);
    check("par_data", 32'(rx_data_b), 32'hA7);
    check("par_perr", 32'(rx_perr_b), 32'd0);
    check("par_ferr", 32'(rx_ferr_b), 32'd0);
    pop(1'b1);
    lb_b = 1'b0;
    drive_frame(8'hA7, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clock);
    check("bad_par_data", 32'(rx_data_b), 32'hA7);
    check("bad_par_perr", 32'(rx_perr_b), 32'd1);
    check("bad_par_ferr", 32'(rx_ferr_b), 32'd0);
    pop(1'b1);
    drive_frame(8'h00, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clock);
    check("zero_par_data", 32'(rx_data_b), 32'h00);
    check("zero_par_perr", 32'(rx_perr_b), 32'd0);
    check("zero_par_valid", 32'(rx_valid_b), 32'd1);
    pop(1'b1);
    lb_b = 1'b1;

    // Reset three bit-times into a frame, then a clean frame
    sel = 1'b0;
    tx_data   = 8'h99;
    tx_send_a = 1'b1;
    @(negedge clock);
    tx_send_a = 1'b0;
    repeat (3 * DIV - 1) @(negedge clock);
    check("mid_busy", 32'(tx_busy_a), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("abort_tx",    32'(tx_a),       32'd1);
    check("abort_busy",  32'(tx_busy_a),  32'd0);
    check("abort_level", 32'(rx_level_a), 32'd0);
    reset = 1'b0;
    repeat (10 * DIV) @(negedge clock);
    check("abort_no_push", 32'(rx_level_a), 32'd0);
    send(1'b0, 8'hC3, -1, -1, n, f, s);
    check("post_rst_len", 32'(n), 32'd160);
    wait_valid(1'b0, 64);
    check("post_rst_level", 32'(rx_level_a), 32'd1);
    check("post_rst_data",  32'(rx_data_a),  32'hC3);
    check("post_rst_perr",  32'(rx_perr_a),  32'd0);
    check("post_rst_ferr",  32'(rx_ferr_a),  32'd0);
    pop(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
